// File: rtl/serial_rx_8b_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding,
// frame constants and the idle level of the line.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam int   CPB_MIN   = 4;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_rx_8b_if.sv
// Receive-side bundle: serial line and bit-order select in, byte and
// status strobes out. The transmitter/test side uses master, the receiver slave.
interface serial_rx_8b_if;

  logic       SDI;
  logic       LSBF;
  logic [7:0] Q;
  logic       VALID;
  logic       FERR;
  logic       BUSY;

  modport master (
    output SDI,
    output LSBF,
    input  Q,
    input  VALID,
    input  FERR,
    input  BUSY
  );

  modport slave (
    input  SDI,
    input  LSBF,
    output Q,
    output VALID,
    output FERR,
    output BUSY
  );

endinterface

// File: rtl/serial_rx_8b_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like activity out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic CLRb,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/serial_rx_8b.sv
// Serial-to-parallel receiver: start/8 data/stop frames at CPB clocks per bit,
// selectable bit order latched at start detect, one-cycle VALID/FERR strobes.
module serial_rx_8b
  import serial_pkg::*;
#(
  parameter int CPB = 16
) (
  input logic           CLK,
  input logic           CLRb,
  serial_rx_8b_if.slave bus
);

  localparam int TW    = $clog2(CPB);
  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [TW-1:0]    HALF_LAST = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0]    BIT_LAST  = TW'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_BITS - 1);

  // Elaboration-time guard on the bit period.
  if ((CPB % 2) != 0 || CPB < CPB_MIN) begin : g_bad_cpb
    $error("serial_rx_8b: CPB must be even and at least %0d", CPB_MIN);
  end

  logic                 sdi_s;
  state_t               state_reg;
  logic [TW-1:0]        timer_reg;
  logic [CNT_W-1:0]     bitcnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 lsbf_reg;
  logic [DATA_BITS-1:0] q_reg;
  logic                 valid_reg;
  logic                 ferr_reg;
  logic                 busy_reg;

  sync_2ff #(
    .RST_VAL (LINE_IDLE)
  ) u_sync_sdi (
    .CLK  (CLK),
    .CLRb (CLRb),
    .d    (bus.SDI),
    .q    (sdi_s)
  );

  // Frame FSM with bit timer, bit counter, shift buffer and registered outputs.
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      bitcnt_reg <= '0;
      shift_reg  <= '0;
      lsbf_reg   <= 1'b0;
      q_reg      <= '0;
      valid_reg  <= 1'b0;
      ferr_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sdi_s != LINE_IDLE) begin
            state_reg <= START;
            timer_reg <= '0;
            lsbf_reg  <= bus.LSBF;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          // Re-check the start bit in its middle to reject short glitches.
          if (timer_reg == HALF_LAST) begin
            timer_reg <= '0;
            if (sdi_s == LINE_IDLE) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg  <= DATA;
              bitcnt_reg <= '0;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DATA: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg <= '0;
            if (lsbf_reg) begin
              shift_reg <= {sdi_s, shift_reg[DATA_BITS-1:1]};
            end else begin
              shift_reg <= {shift_reg[DATA_BITS-2:0], sdi_s};
            end
            if (bitcnt_reg == CNT_LAST) begin
              state_reg <= STOP;
            end else begin
              bitcnt_reg <= bitcnt_reg + 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        STOP: begin
          if (timer_reg == BIT_LAST) begin
            timer_reg <= '0;
            if (sdi_s == LINE_IDLE) begin
              q_reg     <= shift_reg;
              valid_reg <= 1'b1;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= WAIT_HI;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WAIT_HI: begin
          // A line stuck low after a framing error must not look like a new start.
          if (sdi_s == LINE_IDLE) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q     = q_reg;
  assign bus.VALID = valid_reg;
  assign bus.FERR  = ferr_reg;
  assign bus.BUSY  = busy_reg;

endmodule
